// File: rtl/mod5_slot_arbiter.sv
// ---------------------------------------------------------------------------
// mod5_slot_arbiter
//
// Round-robin arbiter sharing one downstream resource among up to five
// requesters. A modulo-NREQ priority pointer sets the scan start; the winner
// receives a registered one-hot grant. A per-tenure hold counter forces a
// release when a holder keeps the grant too long. Every tenure is followed by
// exactly one zero-grant GAP cycle.
//
// Parameters:
//   NREQ      number of requesters (2..5)
//   MAX_HOLD  maximum consecutive grant cycles per tenure (2..255)
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   req        level-sensitive request lines, one per requester
//   done       release strobe; only the current holder's bit is looked at
//   gnt        registered one-hot grant
//   gnt_id     index of the current holder (valid with gnt_valid)
//   gnt_valid  high exactly when gnt is non-zero
//   timeout    one-cycle pulse in the GAP cycle following a forced release
//
// Build option:
//   MOD5_SLOT_ARB_TDM_EN  when defined, strict time-division: only requester
//                         ptr is eligible and ptr walks one step per idle
//                         cycle. Undefined: work-conserving cyclic scan.
// ---------------------------------------------------------------------------
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no holder; arbitrate every cycle
// GRANT | one requester holds gnt; hold_cnt counts the tenure length
// GAP   | single zero-grant turnaround cycle; arbitrate as in IDLE
//
module mod5_slot_arbiter #(
  parameter int NREQ     = 5,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      gnt_id,
  output logic            gnt_valid,
  output logic            timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [2:0] LAST_ID  = 3'(NREQ - 1);
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  state_t          state;
  logic [2:0]      ptr;
  logic [7:0]      hold_cnt;

  logic            win_found;
  logic [2:0]      win_id;
  logic [NREQ-1:0] win_oh;
  logic            holder_rel;
  logic            holder_limit;

  function automatic logic [2:0] next_id(input logic [2:0] id);
    return (id == LAST_ID) ? 3'd0 : id + 3'd1;
  endfunction

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
`ifdef MOD5_SLOT_ARB_TDM_EN
  // Only the requester under the pointer may win.
  always_comb begin
    win_found = req[ptr];
    win_id    = ptr;
  end
`else
  logic [3:0] scan_sum;
  logic [2:0] scan_id;

  // Cyclic scan starting at ptr; the first asserted request wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = 3'd0;
    scan_sum  = 4'd0;
    scan_id   = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      scan_sum = {1'b0, ptr} + 4'(i);
      if (scan_sum >= 4'(NREQ)) begin
        scan_sum = scan_sum - 4'(NREQ);
      end
      scan_id = scan_sum[2:0];
      if (!win_found && req[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
    end
  end
`endif

  always_comb begin
    win_oh         = '0;
    win_oh[win_id] = 1'b1;
  end

  // A normal release takes precedence over the hold limit, so done on the
  // last allowed cycle never raises timeout.
  assign holder_rel   = done[gnt_id] | ~req[gnt_id];
  assign holder_limit = (hold_cnt >= HOLD_LIM);

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      hold_cnt  <= 8'd0;
      gnt       <= '0;
      gnt_id    <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (win_found) begin
            state     <= GRANT;
            gnt       <= win_oh;
            gnt_id    <= win_id;
            gnt_valid <= 1'b1;
            hold_cnt  <= 8'd0;
          end else begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
`ifdef MOD5_SLOT_ARB_TDM_EN
            // Empty slot: move on to the next requester's slot.
            ptr       <= next_id(ptr);
`endif
          end
        end

        GRANT: begin
          hold_cnt <= hold_cnt + 8'd1;
          if (holder_rel || holder_limit) begin
            state     <= GAP;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= next_id(gnt_id);
            timeout   <= ~holder_rel;
          end
        end

        default: begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod5_slot_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mod5_slot_arbiter
//
// Directed bench for mod5_slot_arbiter with NREQ=5, MAX_HOLD=4. Inputs are
// driven 1 time unit after each rising edge and outputs are sampled at the
// same point, so each check sees the state registered at the preceding edge.
// ---------------------------------------------------------------------------
module tb_mod5_slot_arbiter;

  localparam int NREQ     = 5;
  localparam int MAX_HOLD = 4;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] done;
  logic [NREQ-1:0] gnt;
  logic [2:0]      gnt_id;
  logic            gnt_valid;
  logic            timeout;

  int nchk;
  int nerr;

  mod5_slot_arbiter #(
    .NREQ     (NREQ),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full output check; gnt_id is only meaningful while a grant is held.
  task automatic expect_out(input string tag, input logic [NREQ-1:0] g,
                            input logic [2:0] id, input logic to);
    chk({tag, "_gnt"},     32'(gnt),       32'(g));
    chk({tag, "_valid"},   32'(gnt_valid), 32'(|g));
    chk({tag, "_timeout"}, 32'(timeout),   32'(to));
    if (g != '0) begin
      chk({tag, "_id"}, 32'(gnt_id), 32'(id));
    end
  endtask

  // Extra empty cycles the time-division build spends walking the pointer
  // to the requester; none in the work-conserving build.
  task automatic tdm_wait(input int n);
`ifdef MOD5_SLOT_ARB_TDM_EN
    for (int k = 0; k < n; k++) begin
      tick();
      chk("tdm_walk_gnt", 32'(gnt), 32'd0);
    end
`else
    if (n < 0) $display("tdm_wait: negative count %0d", n);
`endif
  endtask

  task automatic do_reset(input logic [NREQ-1:0] r);
    rst  = 1'b1;
    req  = r;
    done = '0;
    tick();
    expect_out("rst", '0, 3'd0, 1'b0);
  endtask

  initial begin
    int ids [7] = '{0, 1, 2, 3, 4, 0, 1};
    nchk = 0;
    nerr = 0;
    rst  = 1'b1;
    req  = '0;
    done = '0;

    // 1. Reset holds outputs low even with all requests pending.
    req = 5'b11111;
    tick();
    expect_out("t1_rst_a", '0, 3'd0, 1'b0);
    chk("t1_rst_a_id", 32'(gnt_id), 32'd0);
    tick();
    expect_out("t1_rst_b", '0, 3'd0, 1'b0);
    rst = 1'b0;
    tick();
    expect_out("t1_first", 5'b00001, 3'd0, 1'b0);

    // 2. Single requester, done on the 3rd grant cycle, then re-grant.
    do_reset(5'b00100);
    rst = 1'b0;
    tdm_wait(2);
    tick();
    expect_out("t2_c1", 5'b00100, 3'd2, 1'b0);
    tick();
    expect_out("t2_c2", 5'b00100, 3'd2, 1'b0);
    tick();
    expect_out("t2_c3", 5'b00100, 3'd2, 1'b0);
    done = 5'b00100;
    tick();
    done = '0;
    expect_out("t2_gap", '0, 3'd0, 1'b0);
    tdm_wait(4);
    tick();
    expect_out("t2_regrant", 5'b00100, 3'd2, 1'b0);

    // 3. Rotation with wrap, done on each holder's first cycle.
    do_reset(5'b11111);
    rst = 1'b0;
    tick();
    for (int k = 0; k < 7; k++) begin
      expect_out("t3_grant", 5'(1 << ids[k]), 3'(ids[k]), 1'b0);
      done = 5'(1 << ids[k]);
      tick();
      done = '0;
      expect_out("t3_gap", '0, 3'd0, 1'b0);
      tick();
    end

    // 4. Stuck holder is forced off after MAX_HOLD cycles.
    do_reset(5'b00010);
    rst = 1'b0;
    tdm_wait(1);
    tick();
    for (int c = 0; c < MAX_HOLD; c++) begin
      expect_out("t4_hold", 5'b00010, 3'd1, 1'b0);
      tick();
    end
    expect_out("t4_timeout", '0, 3'd0, 1'b1);
    tdm_wait(4);
    tick();
    expect_out("t4_regrant", 5'b00010, 3'd1, 1'b0);
    // Variant: done on the last allowed cycle is a normal release.
    tick();
    tick();
    tick();
    expect_out("t4v_c4", 5'b00010, 3'd1, 1'b0);
    done = 5'b00010;
    tick();
    done = '0;
    expect_out("t4v_gap", '0, 3'd0, 1'b0);

    // 5. Mode: only the last requester asks, pointer starts at 0.
    do_reset(5'b10000);
    rst = 1'b0;
    tdm_wait(4);
    tick();
    expect_out("t5_grant", 5'b10000, 3'd4, 1'b0);

    // 6. Reset in the middle of requester 3's tenure.
    do_reset(5'b01000);
    rst = 1'b0;
    tdm_wait(3);
    tick();
    expect_out("t6_c1", 5'b01000, 3'd3, 1'b0);
    tick();
    expect_out("t6_c2", 5'b01000, 3'd3, 1'b0);
    rst = 1'b1;
    tick();
    expect_out("t6_rst", '0, 3'd0, 1'b0);
    chk("t6_rst_id", 32'(gnt_id), 32'd0);
    req = 5'b11111;
    rst = 1'b0;
    tick();
    expect_out("t6_after", 5'b00001, 3'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
